// File: rtl/cpu_pkg.sv
// Shared constants and types for the register-file write-back path.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int NREG   = 2 ** ADDR_W;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    // "reg" is a keyword, so the destination field is named wreg.
    typedef struct packed {
        logic [ADDR_W-1:0] wreg;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of requester handshakes, register-file write port and scoreboard
// signals shared by the write-back arbiter and whoever drives it.
interface regfile_wb_arbiter_if;
    import cpu_pkg::*;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_reg;
    logic              issue_stall;
    logic [NREG-1:0]   busy;

    modport master (
        output alu_valid, alu_reg, alu_data,
        input  alu_ready,
        output mem_valid, mem_reg, mem_data,
        input  mem_ready,
        input  wr_en, wr_reg, wr_data,
        output issue_valid, issue_reg,
        input  issue_stall, busy
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        output alu_ready,
        input  mem_valid, mem_reg, mem_data,
        output mem_ready,
        output wr_en, wr_reg, wr_data,
        input  issue_valid, issue_reg,
        output issue_stall, busy
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: bit 0 is the ALU, bit 1 the load path.
// The pointer remembers the last winner and moves only when a grant is issued.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    req_e last_grant;

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == REQ_MEM) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_MEM;
        end else if (grant[0]) begin
            last_grant <= REQ_ALU;
        end else if (grant[1]) begin
            last_grant <= REQ_MEM;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port (ALU vs. load).
// Optional busy-register scoreboard enabled by defining REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    import cpu_pkg::wb_req_t;

    logic              vld_p0;
    logic [1:0]        grant;
    wb_req_t           win_p0;

    logic              vld_p1;
    logic [ADDR_W-1:0] wr_reg_p1;
    logic [DATA_W-1:0] wr_data_p1;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({bus.mem_valid, bus.alu_valid}),
        .grant (grant)
    );

    assign bus.alu_ready = grant[0];
    assign bus.mem_ready = grant[1];

    // p0: accepted request selected from the winner
    assign vld_p0 = |grant;

    always_comb begin
        win_p0.wreg = bus.alu_reg;
        win_p0.data = bus.alu_data;
        if (grant[1]) begin
            win_p0.wreg = bus.mem_reg;
            win_p0.data = bus.mem_data;
        end
    end

    // p1: registered write port towards the register file
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            wr_reg_p1  <= '0;
            wr_data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                wr_reg_p1  <= win_p0.wreg;
                wr_data_p1 <= win_p0.data;
            end
        end
    end

    assign bus.wr_en   = vld_p1;
    assign bus.wr_reg  = wr_reg_p1;
    assign bus.wr_data = wr_data_p1;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            stall;

    assign stall = bus.issue_valid && busy_q[bus.issue_reg];

    // Set is applied after clear so a same-register issue survives the write-back.
    always_comb begin
        busy_d = busy_q;
        if (vld_p1) begin
            busy_d[wr_reg_p1] = 1'b0;
        end
        if (bus.issue_valid && !stall) begin
            busy_d[bus.issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.issue_stall = stall;
`else
    logic unused_issue;

    assign unused_issue    = ^{bus.issue_valid, bus.issue_reg};
    assign bus.busy        = '0;
    assign bus.issue_stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table plus hand-written corner sequences,
// with a queue of expected register-file writes checked one cycle after acceptance.
module tb_regfile_wb_arbiter;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } wr_t;

    typedef struct {
        logic              av;
        logic [ADDR_W-1:0] ar;
        logic [DATA_W-1:0] ad;
        logic              mv;
        logic [ADDR_W-1:0] mr;
        logic [DATA_W-1:0] md;
        logic              ea;
        logic              em;
    } vec_t;

    localparam int NVEC = 14;

    vec_t vec [NVEC];
    wr_t  exp_q [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [DATA_W-1:0] rf [NREG];

    // Register-file model: commits the write port on the edge after wr_en.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) rf[k] <= '0;
        end else if (bus.wr_en === 1'b1) begin
            rf[bus.wr_reg] <= bus.wr_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                          input logic mv, input logic [ADDR_W-1:0] mr, input logic [DATA_W-1:0] md);
        bus.alu_valid = av;
        bus.alu_reg   = ar;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_reg   = mr;
        bus.mem_data  = md;
    endtask

    // Advance one edge, then compare the write port against the expected queue.
    task automatic clock_check(input string tag);
        wr_t w;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk({tag, ".wr_en"},   32'(bus.wr_en),   1);
            chk({tag, ".wr_reg"},  32'(bus.wr_reg),  32'(w.r));
            chk({tag, ".wr_data"}, 32'(bus.wr_data), 32'(w.d));
        end else begin
            chk({tag, ".wr_en_idle"}, 32'(bus.wr_en), 0);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            av ar  ad     mv mr  md     ea em
        vec[0]  = '{1'b1, 2'd1, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0};
        vec[1]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
        vec[2]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
        vec[3]  = '{1'b1, 2'd2, 8'h11, 1'b1, 2'd3, 8'h22, 1'b0, 1'b1};
        vec[4]  = '{1'b1, 2'd2, 8'h11, 1'b1, 2'd3, 8'h23, 1'b1, 1'b0};
        vec[5]  = '{1'b1, 2'd2, 8'h12, 1'b1, 2'd3, 8'h23, 1'b0, 1'b1};
        vec[6]  = '{1'b1, 2'd2, 8'h12, 1'b1, 2'd3, 8'h24, 1'b1, 1'b0};
        vec[7]  = '{1'b1, 2'd0, 8'hAA, 1'b1, 2'd0, 8'hBB, 1'b0, 1'b1};
        vec[8]  = '{1'b1, 2'd0, 8'hAA, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0};
        vec[9]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h77, 1'b0, 1'b1};
        vec[10] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h78, 1'b0, 1'b1};
        vec[11] = '{1'b1, 2'd3, 8'h99, 1'b1, 2'd1, 8'h01, 1'b1, 1'b0};
        vec[12] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h01, 1'b0, 1'b1};
        vec[13] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};

        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        bus.issue_valid = 1'b0;
        bus.issue_reg   = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst.wr_en",   32'(bus.wr_en),       0);
        chk("rst.wr_reg",  32'(bus.wr_reg),      0);
        chk("rst.wr_data", 32'(bus.wr_data),     0);
        chk("rst.busy",    32'(bus.busy),        0);
        chk("rst.stall",   32'(bus.issue_stall), 0);

        for (int i = 0; i < NVEC; i++) begin
            set_in(vec[i].av, vec[i].ar, vec[i].ad, vec[i].mv, vec[i].mr, vec[i].md);
            #1;
            chk($sformatf("vec%0d.alu_ready", i), 32'(bus.alu_ready), 32'(vec[i].ea));
            chk($sformatf("vec%0d.mem_ready", i), 32'(bus.mem_ready), 32'(vec[i].em));
            if (vec[i].ea) exp_q.push_back('{r: vec[i].ar, d: vec[i].ad});
            else if (vec[i].em) exp_q.push_back('{r: vec[i].mr, d: vec[i].md});
            clock_check($sformatf("vec%0d", i));
        end
        clock_check("flush");
        chk("rf0.last_write_wins", 32'(rf[0]), 32'h0000_00AA);
        chk("rf1.final",           32'(rf[1]), 32'h0000_0001);
        chk("rf3.final",           32'(rf[3]), 32'h0000_0099);

`ifdef REGFILE_WB_SCOREBOARD_EN
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 2'd2;
        #1;
        chk("sb.issue2.stall", 32'(bus.issue_stall), 0);
        clock_check("sb.issue2");
        chk("sb.issue2.busy", 32'(bus.busy), 32'b0100);
        chk("sb.reissue2.stall", 32'(bus.issue_stall), 1);
        clock_check("sb.reissue2");
        chk("sb.reissue2.busy", 32'(bus.busy), 32'b0100);
        bus.issue_valid = 1'b0;

        set_in(1'b1, 2'd2, 8'h66, 1'b0, '0, '0);
        #1;
        chk("sb.wb2.alu_ready", 32'(bus.alu_ready), 1);
        exp_q.push_back('{r: 2'd2, d: 8'h66});
        clock_check("sb.wb2");
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        chk("sb.wb2.busy_held", 32'(bus.busy), 32'b0100);
        clock_check("sb.wb2.idle");
        chk("sb.wb2.busy_clr", 32'(bus.busy), 32'b0000);

        set_in(1'b1, 2'd1, 8'h67, 1'b0, '0, '0);
        #1;
        exp_q.push_back('{r: 2'd1, d: 8'h67});
        clock_check("sb.wb1");
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 2'd1;
        #1;
        chk("sb.simul.stall", 32'(bus.issue_stall), 0);
        clock_check("sb.simul");
        bus.issue_valid = 1'b0;
        chk("sb.simul.busy", 32'(bus.busy), 32'b0010);
`else
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 2'd2;
        #1;
        chk("nosb.stall", 32'(bus.issue_stall), 0);
        clock_check("nosb.issue");
        chk("nosb.busy", 32'(bus.busy), 0);
        bus.issue_valid = 1'b0;
`endif

        // Mid-operation reset: the write accepted alongside rst must not reach the port.
        set_in(1'b1, 2'd1, 8'h33, 1'b0, '0, '0);
        #1;
        exp_q.push_back('{r: 2'd1, d: 8'h33});
        clock_check("mid.pre");
        set_in(1'b1, 2'd2, 8'h34, 1'b0, '0, '0);
        rst = 1'b1;
        clock_check("mid.rst");
        rst = 1'b0;
        chk("mid.busy", 32'(bus.busy), 0);
        set_in(1'b1, 2'd2, 8'h44, 1'b1, 2'd3, 8'h55);
        #1;
        chk("mid.alu_ready", 32'(bus.alu_ready), 1);
        chk("mid.mem_ready", 32'(bus.mem_ready), 0);
        exp_q.push_back('{r: 2'd2, d: 8'h44});
        clock_check("mid.first");
        set_in(1'b0, '0, '0, 1'b1, 2'd3, 8'h55);
        #1;
        chk("mid.mem_next", 32'(bus.mem_ready), 1);
        exp_q.push_back('{r: 2'd3, d: 8'h55});
        clock_check("mid.second");
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        clock_check("mid.idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
